bcd_updown_counter: RTL
=======================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD decades; legal range 1..8.
REQ-002 Parameter SATURATE, default 0: 0 selects wrap-around at the count limits; 1 selects hold at the count limits.
REQ-003 CK  input  1  sole clock; all state changes on the falling edge of CK.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 CLR  input  1  synchronous clear.
REQ-006 LD  input  1  synchronous parallel load.
REQ-007 D  input  4*DIGITS  load value; digit i is D[4i+3:4i]; digit 0 is least significant.
REQ-008 EN  input  1  count enable.
REQ-009 UP  input  1  direction: 1 counts up, 0 counts down.
REQ-010 Q  output  4*DIGITS  registered BCD count, same digit layout as D.
REQ-011 TC  output  1  combinational terminal count.
REQ-012 WRAP  output  1  registered one-cycle wrap/limit pulse.
REQ-013 ERR  output  1  registered sticky flag for an invalid load digit.

Function
REQ-014 Operation priority on each falling CK edge SHALL be: CLR, then LD, then EN count, otherwise hold.
REQ-015 CLR=1: Q SHALL become 0, WRAP SHALL become 0, and ERR SHALL become 0.
REQ-016 LD=1 with CLR=0: each digit of Q SHALL take the corresponding digit of D, except that any digit with value 10..15 SHALL load as 0 and set ERR to 1.
REQ-017 LD=1: WRAP SHALL be 0 on the next cycle; EN and UP SHALL be ignored in the load cycle.
REQ-018 ERR SHALL remain 1 until CLR or reset; a later valid load SHALL NOT clear ERR.
REQ-019 Up count (EN=1, UP=1): digit 0 SHALL increment by 1.
REQ-020 Up count: digit i>0 SHALL increment only when digits 0..i-1 are all 9.
REQ-021 Up count: any digit that increments from 9 SHALL become 0.
REQ-022 Down count (EN=1, UP=0): digit 0 SHALL decrement by 1.
REQ-023 Down count: digit i>0 SHALL decrement only when digits 0..i-1 are all 0.
REQ-024 Down count: any digit that decrements from 0 SHALL become 9.
REQ-025 Limits: the up limit SHALL be all digits 9; the down limit SHALL be all digits 0.
REQ-026 TC SHALL be EN AND (Q at the up limit when UP=1, or Q at the down limit when UP=0); TC SHALL be independent of CLR and LD.
REQ-027 SATURATE=0: counting past a limit SHALL wrap (up limit -> all 0; down limit -> all 9) and set WRAP to 1 for exactly the following cycle.
REQ-028 SATURATE=1: counting at a limit in the direction of that limit SHALL hold Q and set WRAP to 1 for the following cycle; WRAP SHALL stay 1 every cycle that the hold repeats.
REQ-029 In every other case, WRAP SHALL be 0 after each edge.
REQ-030 A change of UP SHALL take effect on the first edge at which it is sampled, with no extra latency and no lost count.
REQ-031 The counter SHALL never hold a non-BCD digit value.
REQ-032 DIGITS=1 SHALL behave as a single decade with all of the above rules.
REQ-033 The design SHALL be fully synchronous to CK with no ripple clocking; Q SHALL be glitch-free, registered outputs.

Reset
REQ-034 RST=0 SHALL immediately, without waiting for CK, force Q=0, WRAP=0 and ERR=0.
REQ-035 These outputs SHALL hold while RST=0, including in the middle of a count.
REQ-036 Operation SHALL resume on the first falling CK edge after RST returns to 1.
REQ-037 TC SHALL reflect the reset value of Q while RST=0 (TC=1 if EN=1 and UP=0).

Verification
REQ-038 DIGITS=2, SATURATE=0: reset, then EN=1, UP=1 for 100 edges -> Q steps 00..99 then 00; WRAP=1 only in the cycle after the 99->00 edge; TC=1 only while Q=99.
REQ-039 DIGITS=2: LD with D=0x30, then UP=0 for 2 edges -> Q=29, then 28.
REQ-040 DIGITS=2, SATURATE=0: count down from 00 -> Q=99, WRAP pulses once.
REQ-041 DIGITS=2: LD with D=0x4C -> Q=40 and ERR=1; a later LD with D=0x12 -> Q=12 with ERR still 1; CLR -> Q=00, ERR=0.
REQ-042 DIGITS=2, SATURATE=1: at Q=99 with UP=1 for 3 edges -> Q stays 99 and WRAP=1 for 3 cycles; UP=0 -> Q=98 and WRAP=0.
REQ-043 DIGITS=2: assert RST=0 between edges at Q=57 -> Q=00 without a CK edge; CLR=1 with LD=1 and EN=1 on the same edge -> Q=00.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//   Cascaded BCD up/down counter with synchronous clear, parallel load,
//   wrap or saturate behaviour at the count limits, a wrap/limit pulse and a
//   sticky invalid-load flag. All state changes on the falling edge of CK.
//
// Ports
//   CK    in   sole clock, falling-edge active
//   RST   in   asynchronous reset, active low
//   CLR   in   synchronous clear (highest priority)
//   LD    in   synchronous parallel load
//   D     in   load value, digit i = D[4i+3:4i], digit 0 least significant
//   EN    in   count enable
//   UP    in   direction, 1 = up, 0 = down
//   Q     out  registered BCD count, same layout as D
//   TC    out  combinational terminal count
//   WRAP  out  registered one-cycle wrap / limit-hold pulse
//   ERR   out  registered sticky flag, set by loading a digit of 10..15
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  LD,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  EN,
  input  logic                  UP,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  WRAP,
  output logic                  ERR
);

  logic [4*DIGITS-1:0] cnt_nxt;
  logic [4*DIGITS-1:0] load_val;
  logic                load_bad;
  logic                at_up;
  logic                at_dn;
  logic                at_lim;
  logic [DIGITS:0]     cy;

  // Next count in the selected direction. cy[i] means every lower digit is at
  // its rollover value (9 going up, 0 going down), so digit i must step.
  // Stepping past the limit naturally produces the wrapped value.
  always_comb begin
    cnt_nxt = Q;
    cy      = '0;
    cy[0]   = 1'b1;
    at_up   = 1'b1;
    at_dn   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      at_up = at_up & (Q[4*i +: 4] == 4'd9);
      at_dn = at_dn & (Q[4*i +: 4] == 4'd0);
      if (UP) begin
        cy[i+1] = cy[i] & (Q[4*i +: 4] == 4'd9);
        if (cy[i])
          cnt_nxt[4*i +: 4] = (Q[4*i +: 4] == 4'd9) ? 4'd0 : Q[4*i +: 4] + 4'd1;
      end else begin
        cy[i+1] = cy[i] & (Q[4*i +: 4] == 4'd0);
        if (cy[i])
          cnt_nxt[4*i +: 4] = (Q[4*i +: 4] == 4'd0) ? 4'd9 : Q[4*i +: 4] - 4'd1;
      end
    end
  end

  // Load value with non-BCD digits forced to 0 so Q never holds 10..15.
  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (D[4*i +: 4] > 4'd9)
        load_bad = 1'b1;
      else
        load_val[4*i +: 4] = D[4*i +: 4];
    end
  end

  assign at_lim = UP ? at_up : at_dn;
  assign TC     = EN & at_lim;

  always_ff @(negedge CK or negedge RST) begin
    if (!RST) begin
      Q    <= '0;
      WRAP <= 1'b0;
      ERR  <= 1'b0;
    end else if (CLR) begin
      Q    <= '0;
      WRAP <= 1'b0;
      ERR  <= 1'b0;
    end else if (LD) begin
      Q    <= load_val;
      WRAP <= 1'b0;
      ERR  <= ERR | load_bad;
    end else if (EN) begin
      // In saturate mode a count into the limit holds Q but still pulses WRAP.
      if (!(SATURATE && at_lim))
        Q <= cnt_nxt;
      WRAP <= at_lim;
    end else begin
      WRAP <= 1'b0;
    end
  end

endmodule
